input_arbiter: RTL and testbench
================================

INPUT_ARBITER -- requirements
Module: input_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 32, payload width of one flit.
REQ-002 Parameter ADDR_SIZE, default 4, destination-address field width.
REQ-003 Parameter PORTS_NUM, default 4; the block serves PORTS_NUM+1 requesters (mesh ports plus local port).
REQ-004 Parameter MEM_LOG2, default 5; the downstream queue depth is 2**MEM_LOG2 flits.
REQ-005 Localparam BUS_SIZE = DATA_SIZE+ADDR_SIZE+1, the flit width.
REQ-006 Clock and reset: one clock; reset is synchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 a_rst  input  1  synchronous reset, active-low.
REQ-009 wr_ready_in  input  PORTS_NUM+1  per-port request; bit i high means port i presents a valid flit.
REQ-010 data_i  input  BUS_SIZE*(PORTS_NUM+1)  per-port flits; port i at [i*BUS_SIZE +: BUS_SIZE].
REQ-011 mem_readed  input  1  single-cycle pulse; one flit was popped from the queue.
REQ-012 r_ready_out  output  PORTS_NUM+1  one-hot acknowledge; the flit from port i was taken.
REQ-013 wr_req  output  1  queue write strobe.
REQ-014 data_o  output  BUS_SIZE  flit to the queue; valid while wr_req is high.
REQ-015 occupancy  output  MEM_LOG2+1  credit count: flits queued plus flits granted but not yet written.

Function
REQ-016 The block computes eligible = wr_ready_in & ~r_ready_out each cycle; the port acknowledged in the current cycle is excluded.
REQ-017 A grant is issued in a cycle iff eligible != 0 and occupancy < 2**MEM_LOG2.
REQ-018 The winner is the first eligible port found searching upward from rr_ptr, with wrap-around modulo PORTS_NUM+1.
REQ-019 On the clock edge ending a grant cycle, the registered outputs change as follows: r_ready_out = one-hot(winner), wr_req = 1, and data_o = data_i slice of the winner.
REQ-020 Grant latency is one cycle, from the request sampled to the ack/write visible.
REQ-021 In a cycle with no grant, on the next edge r_ready_out = 0 and wr_req = 0, and data_o holds its value.
REQ-022 After a grant to port k, rr_ptr becomes (k+1) mod (PORTS_NUM+1); without a grant, rr_ptr holds.
REQ-023 Handshake rules: a requester holds wr_ready_in and its data until it sees its r_ready_out bit high, and advances on that edge; a single port is therefore granted at most every other cycle.
REQ-024 occupancy changes by +1 on a grant edge and by -1 on a mem_readed edge; when both occur in the same cycle, occupancy is unchanged.
REQ-025 A mem_readed pulse while occupancy = 0 is ignored, and occupancy stays 0.
REQ-026 occupancy never exceeds 2**MEM_LOG2; at that value no grant is issued, even with requests pending.
REQ-027 wr_req and r_ready_out are always asserted together and are never multi-hot.

Reset
REQ-028 While a_rst = 0 at a rising edge, the following are cleared: r_ready_out = 0, wr_req = 0, data_o = 0, occupancy = 0, rr_ptr = 0.
REQ-029 Reset mid-operation discards any pending write and all credit state; wr_req is 0 in the first cycle after reset.
REQ-030 The first grant after reset favours port 0 when it is requesting.

Structure
REQ-031 BUS_SIZE derivation and the ceiling-log2 constant function belong in shared package switch_pkg, used by this block and by the switch datapath.
REQ-032 The rotate-and-priority-pick logic is one sub-module, rr_pick, which is combinational: inputs are the eligible mask and the pointer; outputs are a one-hot grant and a valid flag.
REQ-033 All remaining state (pointer, credit counter, output registers) resides in input_arbiter.

Verification (PORTS_NUM=4, MEM_LOG2=2, depth 4)
REQ-034 Reset, then wr_ready_in=5'b00001 with flit 0xA held -> next cycle r_ready_out=00001, wr_req=1, data_o=0xA, occupancy=1.
REQ-035 All five ports request continuously, mem_readed pulsing every cycle -> grants rotate 0,1,2,3,4,0, with none skipped and none repeated back-to-back.
REQ-036 All ports request, no mem_readed -> exactly 4 grants occur, then wr_req stays 0 and occupancy=4; one mem_readed pulse -> exactly one more grant.
REQ-037 occupancy=2 with a grant and mem_readed in the same cycle -> occupancy stays 2; mem_readed at occupancy 0 -> occupancy stays 0.
REQ-038 Only port 3 requests, held high continuously -> r_ready_out[3] alternates 1,0,1,0; the ack cycle is never re-granted.
REQ-039 a_rst=0 asserted in the cycle after a grant, with requests pending -> all outputs 0 after that edge, occupancy=0, and the next grant goes to the lowest-numbered requester.

Source files
------------

// File: rtl/switch_pkg.sv
// switch_pkg -- constants and helpers shared by the switch datapath and
// its input arbiters.
//
// Contents:
//   clog2      ceiling log2 of a positive integer (clog2(1) = 0)
//   ptr_width  width of an index into n items, never less than 1 bit
//   bus_size   flit width: payload + destination address + 1 flag bit
package switch_pkg;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  // A one-item index still needs a real bit so that port declarations
  // never collapse to a zero-width vector.
  function automatic int ptr_width(input int count);
    return (clog2(count) > 0) ? clog2(count) : 1;
  endfunction

  function automatic int bus_size(input int data_size, input int addr_size);
    return data_size + addr_size + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin selector.
//
// Searches the eligible mask upward from ptr, wrapping modulo N, and
// returns the first set bit as a one-hot grant.
//
// Ports:
//   eligible  in   N      request mask already filtered by the caller
//   ptr       in   PTR_W  highest-priority index for this cycle
//   grant     out  N      one-hot winner (all zero when nothing eligible)
//   valid     out  1      high when grant is non-zero
module rr_pick #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/input_arbiter.sv
// input_arbiter -- round-robin arbiter feeding one switch output queue.
//
// PORTS_NUM+1 requesters (mesh ports plus the local port) compete for a
// downstream queue of 2**MEM_LOG2 flits. A credit counter (occupancy)
// tracks flits queued plus flits granted but not yet popped, so no grant
// is issued once the queue could be full.
//
// Ports:
//   clk          in   1                       rising-edge clock
//   a_rst        in   1                       synchronous reset, active-low
//   wr_ready_in  in   PORTS_NUM+1             per-port valid flit
//   data_i       in   BUS_SIZE*(PORTS_NUM+1)  per-port flits, port i at [i*BUS_SIZE +: BUS_SIZE]
//   mem_readed   in   1                       one flit popped from the queue
//   r_ready_out  out  PORTS_NUM+1             one-hot acknowledge to the winner
//   wr_req       out  1                       queue write strobe
//   data_o       out  BUS_SIZE                flit written to the queue
//   occupancy    out  MEM_LOG2+1              credit count
module input_arbiter
  import switch_pkg::*;
#(
  parameter  int DATA_SIZE = 32,
  parameter  int ADDR_SIZE = 4,
  parameter  int PORTS_NUM = 4,
  parameter  int MEM_LOG2  = 5,
  localparam int BUS_SIZE  = bus_size(DATA_SIZE, ADDR_SIZE)
) (
  input  logic                              clk,
  input  logic                              a_rst,
  input  logic [PORTS_NUM:0]                wr_ready_in,
  input  logic [BUS_SIZE*(PORTS_NUM+1)-1:0] data_i,
  input  logic                              mem_readed,
  output logic [PORTS_NUM:0]                r_ready_out,
  output logic                              wr_req,
  output logic [BUS_SIZE-1:0]               data_o,
  output logic [MEM_LOG2:0]                 occupancy
);

  localparam int N     = PORTS_NUM + 1;
  localparam int PTR_W = ptr_width(N);
  localparam int DEPTH = 1 << MEM_LOG2;

  localparam logic [MEM_LOG2:0] DEPTH_V = DEPTH[MEM_LOG2:0];
  localparam logic [MEM_LOG2:0] OCC_ONE = {{MEM_LOG2{1'b0}}, 1'b1};

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    ptr_next;
  logic [N-1:0]        eligible;
  logic [N-1:0]        pick;
  logic                pick_valid;
  logic                grant_ok;
  logic                pop_ok;
  logic [BUS_SIZE-1:0] win_data;

  // The port acknowledged this cycle is advancing its flit on this edge,
  // so its request line still shows the old flit and must be ignored.
  assign eligible = wr_ready_in & ~r_ready_out;

  rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (pick),
    .valid    (pick_valid)
  );

  assign grant_ok = pick_valid && (occupancy < DEPTH_V);

  // A pop with no credits outstanding is a stray pulse and is dropped so
  // the counter cannot wrap below zero.
  assign pop_ok = mem_readed && (occupancy != '0);

  always_comb begin
    win_data = '0;
    ptr_next = rr_ptr;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        win_data = data_i[i*BUS_SIZE +: BUS_SIZE];
        ptr_next = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      r_ready_out <= '0;
      wr_req      <= 1'b0;
      data_o      <= '0;
      occupancy   <= '0;
      rr_ptr      <= '0;
    end else begin
      if (grant_ok) begin
        r_ready_out <= pick;
        wr_req      <= 1'b1;
        data_o      <= win_data;
        rr_ptr      <= ptr_next;
      end else begin
        r_ready_out <= '0;
        wr_req      <= 1'b0;
      end

      if (grant_ok && !pop_ok) begin
        occupancy <= occupancy + OCC_ONE;
      end else if (!grant_ok && pop_ok) begin
        occupancy <= occupancy - OCC_ONE;
      end
    end
  end

endmodule

// File: tb/tb_input_arbiter.sv
// tb_input_arbiter -- directed bench for input_arbiter with PORTS_NUM=4,
// MEM_LOG2=2 (queue depth 4). Each step drives inputs, pushes the
// reference model's prediction to a scoreboard queue, then pops and
// compares after the next rising edge.
module tb_input_arbiter;

  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 4;
  localparam int PORTS_NUM = 4;
  localparam int MEM_LOG2  = 2;
  localparam int BUS       = DATA_SIZE + ADDR_SIZE + 1;
  localparam int N         = PORTS_NUM + 1;
  localparam int DEPTH     = 1 << MEM_LOG2;

  typedef struct {
    logic [N-1:0]   ack;
    logic           wr;
    logic [BUS-1:0] data;
    int             occ;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 a_rst;
  logic [N-1:0]         wr_ready_in;
  logic [BUS*N-1:0]     data_i;
  logic                 mem_readed;
  logic [N-1:0]         r_ready_out;
  logic                 wr_req;
  logic [BUS-1:0]       data_o;
  logic [MEM_LOG2:0]    occupancy;

  logic [BUS-1:0]       flit [N];

  exp_t                 sb [$];
  logic [N-1:0]         m_ack;
  logic [BUS-1:0]       m_data;
  int                   m_ptr;
  int                   m_occ;

  int compared   = 0;
  int mismatched = 0;
  int grants;

  always #5 clk = ~clk;

  always_comb begin
    data_i = '0;
    for (int i = 0; i < N; i++) data_i[i*BUS +: BUS] = flit[i];
  end

  input_arbiter #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE),
    .PORTS_NUM (PORTS_NUM),
    .MEM_LOG2  (MEM_LOG2)
  ) dut (
    .clk         (clk),
    .a_rst       (a_rst),
    .wr_ready_in (wr_ready_in),
    .data_i      (data_i),
    .mem_readed  (mem_readed),
    .r_ready_out (r_ready_out),
    .wr_req      (wr_req),
    .data_o      (data_o),
    .occupancy   (occupancy)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and record what the model says the
  // registered outputs must be after the coming edge.
  task automatic applyStimulus(input logic rst_n, input logic [N-1:0] req, input logic rd);
    exp_t         e;
    logic [N-1:0] elig;
    int           win;
    int           rd_eff;
    a_rst       = rst_n;
    wr_ready_in = req;
    mem_readed  = rd;
    if (!rst_n) begin
      m_ack  = '0;
      m_data = '0;
      m_ptr  = 0;
      m_occ  = 0;
      e.wr   = 1'b0;
    end else begin
      elig   = req & ~m_ack;
      win    = -1;
      for (int off = 0; off < N; off++) begin
        if (win < 0 && elig[(m_ptr + off) % N]) win = (m_ptr + off) % N;
      end
      rd_eff = (rd && m_occ > 0) ? 1 : 0;
      if (win >= 0 && m_occ < DEPTH) begin
        m_ack  = '0;
        m_ack[win] = 1'b1;
        m_data = flit[win];
        m_ptr  = (win + 1) % N;
        m_occ  = m_occ + 1 - rd_eff;
        e.wr   = 1'b1;
      end else begin
        m_ack  = '0;
        m_occ  = m_occ - rd_eff;
        e.wr   = 1'b0;
      end
    end
    e.ack  = m_ack;
    e.data = m_data;
    e.occ  = m_occ;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      checkVal("r_ready_out", 64'(r_ready_out), 64'(e.ack));
      checkVal("wr_req",      64'(wr_req),      64'(e.wr));
      checkVal("data_o",      64'(data_o),      64'(e.data));
      checkVal("occupancy",   64'(occupancy),   64'(e.occ));
    end
  endtask

  task automatic step(input logic rst_n, input logic [N-1:0] req, input logic rd);
    applyStimulus(rst_n, req, rd);
    @(posedge clk);
    #1;
    checkOutput();
    if (wr_req) grants++;
  endtask

  initial begin
    logic [N-1:0] rot_exp [6];
    logic [1:0]   wr_exp  [6];
    rot_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

    flit[0] = 37'h00_0000_000A;
    for (int i = 1; i < N; i++) flit[i] = BUS'(64'h1_0000_0000 * i + 64'h100 * i + 64'h5A);
    a_rst = 1'b0; wr_ready_in = '0; mem_readed = 1'b0;
    m_ack = '0; m_data = '0; m_ptr = 0; m_occ = 0; grants = 0;

    $display("[TB] reset");
    step(1'b0, 5'b11111, 1'b0);
    step(1'b0, 5'b11111, 1'b1);
    checkVal("reset_wr_req", 64'(wr_req), 64'd0);
    checkVal("reset_occ", 64'(occupancy), 64'd0);

    $display("[TB] single grant to port 0");
    step(1'b1, 5'b00001, 1'b0);
    checkVal("first_ack", 64'(r_ready_out), 64'h01);
    checkVal("first_data", 64'(data_o), 64'hA);
    checkVal("first_occ", 64'(occupancy), 64'd1);
    step(1'b1, 5'b00000, 1'b0);
    step(1'b1, 5'b00000, 1'b1);
    step(1'b1, 5'b00000, 1'b1);
    checkVal("pop_at_zero_occ", 64'(occupancy), 64'd0);

    $display("[TB] rotation with continuous pops");
    step(1'b0, 5'b00000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 5'b11111, 1'b1);
      checkVal("rotation_ack", 64'(r_ready_out), 64'(rot_exp[k]));
    end

    $display("[TB] queue fills without pops");
    step(1'b0, 5'b00000, 1'b0);
    wr_exp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 5'b11111, 1'b0);
      checkVal("fill_wr_req", 64'(wr_req), 64'(wr_exp[k]));
    end
    checkVal("full_occ", 64'(occupancy), 64'd4);
    grants = 0;
    step(1'b1, 5'b11111, 1'b1);
    step(1'b1, 5'b11111, 1'b0);
    step(1'b1, 5'b11111, 1'b0);
    checkVal("one_pop_one_grant", 64'(grants), 64'd1);

    $display("[TB] simultaneous grant and pop");
    step(1'b1, 5'b00000, 1'b1);
    step(1'b1, 5'b00000, 1'b1);
    checkVal("drain_to_two", 64'(occupancy), 64'd2);
    step(1'b1, 5'b00010, 1'b1);
    checkVal("grant_and_pop_occ", 64'(occupancy), 64'd2);
    checkVal("grant_and_pop_wr", 64'(wr_req), 64'd1);

    $display("[TB] single port held high");
    step(1'b0, 5'b00000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 5'b01000, 1'b1);
      checkVal("port3_alternate", 64'(r_ready_out[3]), (k % 2 == 0) ? 64'd1 : 64'd0);
    end

    $display("[TB] reset mid-operation");
    step(1'b0, 5'b00000, 1'b0);
    step(1'b1, 5'b11111, 1'b0);
    step(1'b1, 5'b11111, 1'b0);
    step(1'b0, 5'b11110, 1'b0);
    checkVal("midreset_ack", 64'(r_ready_out), 64'd0);
    checkVal("midreset_occ", 64'(occupancy), 64'd0);
    step(1'b1, 5'b11110, 1'b0);
    checkVal("post_reset_lowest", 64'(r_ready_out), 64'h02);

    checkVal("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
